move_commit: RTL and testbench
==============================

// Module: move_commit
// PURPOSE
// - Writer side of the board-update word change_piece = {valid[10], piece[9:6], square[5:0]} consumed by the board register.
// - Accepts one move request (src, dst) over a valid/ready handshake and reads both squares from the 256-bit board vector.
// - Validates the move, then emits exactly two update words: the moving piece to dst, then EMPTY to src.
// - Reports completion, or rejection, plus the captured piece to the game controller.
// PARAMETERS
// - SETTLE_CYCLES  default 2  cycles after the last write word before move_done; covers board write latency; legal range 1..15.
// PORTS
// - clk            in   1    system clock; all logic on posedge
// - rst_n          in   1    asynchronous active-low reset
// - board          in   256  square idx = col*8+row (col 0=A..7=H, row 0=top/black back rank..7=bottom); nibble board[idx*4+3 -: 4]; bit3 colour (0 white, 1 black), bits2:0 type
// - turn           in   1    side to move: 0 white, 1 black; sampled at acceptance
// - move_valid     in   1    request valid
// - move_src       in   6    source square idx
// - move_dst       in   6    destination square idx
// - move_ready     out  1    block idle and accepting
// - change_piece   out  11   update word; bit10 = write strobe
// - move_done      out  1    one-cycle pulse: move written and settled
// - move_err       out  1    one-cycle pulse: move rejected, nothing written
// - captured       out  4    nibble found at dst at acceptance; valid while move_done is high, held until next acceptance
// BEHAVIOUR
// - Type codes: EMPTY 000, KING 001, QUEEN 010, BISHOP 011, KNIGHT 100, ROOK 101, PAWN 110.
// - Reset (async, rst_n=0): state IDLE; move_ready=1; change_piece=0; move_done=0; move_err=0; captured=0.
// - FSM: IDLE -> CHECK -> WR_DST -> WR_SRC -> SETTLE -> DONE -> IDLE; CHECK -> REJECT -> IDLE.
// - IDLE: move_ready=1. On move_valid&&move_ready, latch src, dst, turn, src nibble and dst nibble; go to CHECK.
// - move_ready is 0 in every state except IDLE; move_valid outside IDLE is ignored and not queued.
// - CHECK (1 cycle) rejects the move if any of these hold:
//   - src type == EMPTY
//   - src colour != latched turn
//   - src == dst
//   - dst non-empty and dst colour == src colour
// - Rejected -> REJECT; otherwise -> WR_DST. No movement-geometry check; that is the rules engine's job.
// - All outputs are registered. change_piece[10] is high for exactly two consecutive cycles per accepted legal move:
//   - first word {1, moved_piece, dst}
//   - second word {1, 4'b0000, src}
//   - change_piece = 0 at all other times.
// - SETTLE: counts SETTLE_CYCLES cycles after the second word, then DONE.
// - DONE: move_done=1 for one cycle; captured = latched dst nibble.
// - REJECT: move_err=1 for one cycle; no write word; captured unchanged.
// - Latency: acceptance edge to move_done high = 4+SETTLE_CYCLES cycles. Acceptance to move_err high = 2 cycles.
// - move_ready returns to 1 in the cycle after move_done or move_err.
// - board is sampled only at acceptance; later board changes do not affect an in-flight move.
// - Reset mid-operation aborts at once: outputs return to reset values and no further words are issued.
//   - The board may then hold dst written without src cleared; the controller restarts the game.
// CONFIGURATION
// - PROMOTION_EN defined: moved_piece becomes {colour, QUEEN} when a PAWN reaches the far row (white dst row 0, black dst row 7).
// - PROMOTION_EN undefined: moved_piece is always the src nibble unchanged.
// TESTING
// - Reset: hold rst_n=0 -> move_ready=1, change_piece=0, move_done=0, move_err=0, captured=0.
// - Initial board, turn=0, src=38 (E, white pawn), dst=36:
//   - words 11'h5A4 ({1,0110,100100}) then 11'h426 ({1,0000,100110}), back-to-back
//   - move_done SETTLE_CYCLES cycles after the second word; captured=4'h0.
// - Reject cases, turn=0, each gives one move_err pulse 2 cycles after acceptance and change_piece never strobes:
//   - empty src: src=10, dst=9
//   - wrong colour: src=1 (black pawn), dst=2
//   - own-colour capture: src=28 (white rook), dst=27 (white pawn)
// - Capture: white pawn at 9, black rook nibble 4'hD at 0, turn=0, src=9, dst=0:
//   - with PROMOTION_EN: first word {1,0010,000000}; without: {1,0110,000000}
//   - captured=4'hD in both builds.
// - Busy/reset: pulse move_valid with a second request while in SETTLE -> ignored; exactly one move_done.
//   - Then rst_n=0 between the two words -> second word never appears; move_ready=1 after release.

Source files
------------

// File: rtl/move_commit.sv
// Board-update writer: accepts one (src, dst) move, validates it, emits the dst and src
// update words, then reports done or reject. Define PROMOTION_EN to auto-queen pawns on the far row.
module move_commit #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] board,
  input  logic         turn,
  input  logic         move_valid,
  input  logic [5:0]   move_src,
  input  logic [5:0]   move_dst,
  output logic         move_ready,
  output logic [10:0]  change_piece,
  output logic         move_done,
  output logic         move_err,
  output logic [3:0]   captured
);

  localparam logic [2:0] T_EMPTY = 3'b000;
  localparam logic [2:0] T_QUEEN = 3'b010;
  localparam logic [2:0] T_PAWN  = 3'b110;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_WR_DST = 3'd2,
    S_WR_SRC = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5,
    S_REJECT = 3'd6
  } state_e;

  state_e      state_q;
  logic [5:0]  src_q;
  logic [5:0]  dst_q;
  logic        turn_q;
  logic [3:0]  src_nib_q;
  logic [3:0]  dst_nib_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic [10:0] piece_q;
  logic        done_q;
  logic        err_q;
  logic [3:0]  cap_q;

  logic        reject_d;
  logic [3:0]  moved_d;

  // Move legality: only ownership and occupancy, geometry belongs to the rules engine
  always_comb begin
    reject_d = 1'b0;
    if ((src_nib_q[2:0] == T_EMPTY) ||
        (src_nib_q[3] != turn_q) ||
        (src_q == dst_q) ||
        ((dst_nib_q[2:0] != T_EMPTY) && (dst_nib_q[3] == src_nib_q[3]))) begin
      reject_d = 1'b1;
    end else begin
      reject_d = 1'b0;
    end
  end

  // Piece written to dst; row is the low three bits of the square index
  always_comb begin
    moved_d = src_nib_q;
`ifdef PROMOTION_EN
    if ((src_nib_q[2:0] == T_PAWN) &&
        (((src_nib_q[3] == 1'b0) && (dst_q[2:0] == 3'd0)) ||
         ((src_nib_q[3] == 1'b1) && (dst_q[2:0] == 3'd7)))) begin
      moved_d = {src_nib_q[3], T_QUEEN};
    end else begin
      moved_d = src_nib_q;
    end
`else
    if (src_nib_q[2:0] == T_PAWN) begin
      moved_d = src_nib_q;
    end else begin
      moved_d = src_nib_q;
    end
`endif
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_q     <= 6'd0;
      dst_q     <= 6'd0;
      turn_q    <= 1'b0;
      src_nib_q <= 4'd0;
      dst_nib_q <= 4'd0;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b1;
      piece_q   <= 11'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cap_q     <= 4'd0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      piece_q <= 11'd0;
      case (state_q)
        S_IDLE: begin
          // ready_q is low for the single cycle after done/err, so nothing is accepted then
          if (ready_q && move_valid) begin
            src_q     <= move_src;
            dst_q     <= move_dst;
            turn_q    <= turn;
            src_nib_q <= board[{move_src, 2'b00} +: 4];
            dst_nib_q <= board[{move_dst, 2'b00} +: 4];
            ready_q   <= 1'b0;
            state_q   <= S_CHECK;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_CHECK: begin
          state_q <= reject_d ? S_REJECT : S_WR_DST;
        end
        S_WR_DST: begin
          piece_q <= {1'b1, moved_d, dst_q};
          state_q <= S_WR_SRC;
        end
        S_WR_SRC: begin
          piece_q <= {1'b1, 4'b0000, src_q};
          cnt_q   <= 4'd0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          cap_q   <= dst_nib_q;
          state_q <= S_IDLE;
        end
        S_REJECT: begin
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign move_ready   = ready_q;
  assign change_piece = piece_q;
  assign move_done    = done_q;
  assign move_err     = err_q;
  assign captured     = cap_q;

endmodule

// File: tb/tb_move_commit.sv
// Directed table-driven bench for move_commit plus busy and mid-move reset sequences.
module tb_move_commit;

  localparam int S = 2;

  logic         clk;
  logic         rst_n;
  logic [255:0] board;
  logic         turn;
  logic         move_valid;
  logic [5:0]   move_src;
  logic [5:0]   move_dst;
  logic         move_ready;
  logic [10:0]  change_piece;
  logic         move_done;
  logic         move_err;
  logic [3:0]   captured;

  int checks = 0;
  int failures = 0;

  int          nw, wn0, wn1, dcnt, dn, ecnt, en, ev_n;
  logic [10:0] w0, w1;
  logic [3:0]  cap_done;
  logic        rdy_after;

  move_commit #(.SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .board        (board),
    .turn         (turn),
    .move_valid   (move_valid),
    .move_src     (move_src),
    .move_dst     (move_dst),
    .move_ready   (move_ready),
    .change_piece (change_piece),
    .move_done    (move_done),
    .move_err     (move_err),
    .captured     (captured)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] brd;
    logic [5:0]   src;
    logic [5:0]   dst;
    logic         trn;
    logic         legal;
    logic [10:0]  w1;
    logic [10:0]  w2;
    logic [3:0]   cap;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] init_board();
    logic [255:0] b;
    logic [2:0]   t;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0, 7:    t = 3'd5;
        1, 6:    t = 3'd4;
        2, 5:    t = 3'd3;
        3:       t = 3'd2;
        default: t = 3'd1;
      endcase
      b[(c*8+0)*4 +: 4] = {1'b1, t};
      b[(c*8+1)*4 +: 4] = 4'hE;
      b[(c*8+6)*4 +: 4] = 4'h6;
      b[(c*8+7)*4 +: 4] = {1'b0, t};
    end
    return b;
  endfunction

  // mode 0 plain, 1 extra request during SETTLE, 2 reset after first word
  task automatic run_move(input logic [5:0] s, input logic [5:0] d, input logic t, input int mode);
    nw = 0; wn0 = -1; wn1 = -1; dcnt = 0; dn = -1; ecnt = 0; en = -1; ev_n = -100;
    w0 = 11'd0; w1 = 11'd0; cap_done = 4'd0; rdy_after = 1'b0;
    @(negedge clk);
    move_src = s; move_dst = d; turn = t; move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == ev_n + 1) rdy_after = move_ready;
      if (change_piece[10]) begin
        if (nw == 0) begin w0 = change_piece; wn0 = n; end
        else if (nw == 1) begin w1 = change_piece; wn1 = n; end
        nw++;
      end
      if (move_done) begin dcnt++; dn = n; cap_done = captured; ev_n = n; end
      if (move_err) begin ecnt++; en = n; ev_n = n; end
      if (mode == 1 && n == 4) begin
        move_valid = 1'b1; move_src = 6'd1; move_dst = 6'd3; turn = 1'b0;
      end
      if (mode == 1 && n == 5) move_valid = 1'b0;
      if (mode == 2 && n == 2) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_piece", 32'(change_piece), 32'd0);
        chk("rst_mid_ready", 32'(move_ready), 32'd1);
        break;
      end
    end
  endtask

  vec_t        vt[7];
  logic [255:0] b0, b_own, b_cap;
  logic [3:0]   cap_model;
  logic [10:0]  cap_w1;
  int           strobes;

  initial begin
    rst_n = 1'b0; board = '0; turn = 1'b0; move_valid = 1'b0;
    move_src = 6'd0; move_dst = 6'd0;

`ifdef PROMOTION_EN
    cap_w1 = 11'h480;
`else
    cap_w1 = 11'h580;
`endif
    b0 = init_board();
    b_own = b0; b_own[28*4 +: 4] = 4'h5; b_own[27*4 +: 4] = 4'h6;
    b_cap = b0; b_cap[9*4 +: 4] = 4'h6; b_cap[0*4 +: 4] = 4'hD;

    vt[0] = '{"e_pawn",   b0,    6'd38, 6'd36, 1'b0, 1'b1, 11'h5A4, 11'h426, 4'h0};
    vt[1] = '{"capture",  b_cap, 6'd9,  6'd0,  1'b0, 1'b1, cap_w1,  11'h409, 4'hD};
    vt[2] = '{"empty_src",b0,    6'd10, 6'd9,  1'b0, 1'b0, 11'h0,   11'h0,   4'h0};
    vt[3] = '{"wrong_col",b0,    6'd1,  6'd2,  1'b0, 1'b0, 11'h0,   11'h0,   4'h0};
    vt[4] = '{"own_cap",  b_own, 6'd28, 6'd27, 1'b0, 1'b0, 11'h0,   11'h0,   4'h0};
    vt[5] = '{"same_sq",  b0,    6'd38, 6'd38, 1'b0, 1'b0, 11'h0,   11'h0,   4'h0};
    vt[6] = '{"black_pawn",b0,   6'd1,  6'd3,  1'b1, 1'b1, 11'h783, 11'h401, 4'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(move_ready), 32'd1);
    chk("reset_piece", 32'(change_piece), 32'd0);
    chk("reset_done", 32'(move_done), 32'd0);
    chk("reset_err", 32'(move_err), 32'd0);
    chk("reset_cap", 32'(captured), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cap_model = 4'h0;
    for (int i = 0; i < 7; i++) begin
      board = vt[i].brd;
      run_move(vt[i].src, vt[i].dst, vt[i].trn, 0);
      if (vt[i].legal) begin
        cap_model = vt[i].cap;
        chk({vt[i].name, "_nwords"}, 32'(nw), 32'd2);
        chk({vt[i].name, "_w1"}, 32'(w0), 32'(vt[i].w1));
        chk({vt[i].name, "_w2"}, 32'(w1), 32'(vt[i].w2));
        chk({vt[i].name, "_b2b"}, 32'(wn1 - wn0), 32'd1);
        chk({vt[i].name, "_done_lat"}, 32'(dn), 32'(4 + S));
        chk({vt[i].name, "_ndone"}, 32'(dcnt), 32'd1);
        chk({vt[i].name, "_nerr"}, 32'(ecnt), 32'd0);
        chk({vt[i].name, "_cap"}, 32'(cap_done), 32'(vt[i].cap));
      end else begin
        chk({vt[i].name, "_nerr"}, 32'(ecnt), 32'd1);
        chk({vt[i].name, "_err_lat"}, 32'(en), 32'd2);
        chk({vt[i].name, "_nwords"}, 32'(nw), 32'd0);
        chk({vt[i].name, "_ndone"}, 32'(dcnt), 32'd0);
        chk({vt[i].name, "_cap_hold"}, 32'(captured), 32'(cap_model));
      end
      chk({vt[i].name, "_ready_after"}, 32'(rdy_after), 32'd1);
    end

    // second request during SETTLE must be dropped
    board = b0;
    run_move(6'd38, 6'd36, 1'b0, 1);
    chk("busy_ndone", 32'(dcnt), 32'd1);
    chk("busy_done_lat", 32'(dn), 32'(4 + S));
    chk("busy_nerr", 32'(ecnt), 32'd0);
    chk("busy_nwords", 32'(nw), 32'd2);

    // reset between the two words
    run_move(6'd38, 6'd36, 1'b0, 2);
    chk("rst_first_word", 32'(w0), 32'h5A4);
    strobes = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (change_piece[10] || move_done || move_err) strobes++;
    end
    chk("rst_no_more_words", 32'(strobes), 32'd0);
    chk("rst_ready_after", 32'(move_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
